// File: rtl/vec_rf_pkg.sv
// vec_rf_pkg: shared types and helpers for the vector regfile requester.
//   state_t       controller FSM states
//   lmul_t        LMUL group-size encoding (log2 of register count)
//   lmul_to_nregs registers in a group for a given lmul
//   RF_RD/RF_WR   regfile rw encoding
package vec_rf_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, DRAIN} state_t;
  typedef logic [1:0] lmul_t;
  localparam logic RF_RD = 1'b0;
  localparam logic RF_WR = 1'b1;
  function automatic logic [3:0] lmul_to_nregs(lmul_t l);
    return 4'd1 << l;
  endfunction
endpackage

// File: rtl/vec_rf_requester_if.sv
// vec_rf_requester_if: request, write-beat, read-beat and regfile-port bundle.
//   req_*   request handshake (valid/ready) plus rw/addr/lmul and error pulse
//   wdata_* write beat stream into the controller
//   rdata_* read beat stream out of the controller (no backpressure)
//   rf_*    one regfile port (en/rw/addr/data_in/data_out)
// slave = the controller, master = the issuing logic plus the regfile port.
interface vec_rf_requester_if
  import vec_rf_pkg::*;
#(
  parameter int VLEN_B     = 128,
  parameter int ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_addr;
  lmul_t                 req_lmul;
  logic                  req_err;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [VLEN_B-1:0]     wdata;
  logic                  rdata_valid;
  logic [VLEN_B-1:0]     rdata;
  logic [2:0]            rdata_idx;
  logic                  rdata_last;
  logic                  rf_en;
  logic                  rf_rw;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [VLEN_B-1:0]     rf_wdata;
  logic [VLEN_B-1:0]     rf_rdata;
  modport slave (
    input  req_valid, req_rw, req_addr, req_lmul, wdata_valid, wdata, rf_rdata,
    output req_ready, req_err, wdata_ready, rdata_valid, rdata, rdata_idx, rdata_last,
           rf_en, rf_rw, rf_addr, rf_wdata
  );
  modport master (
    output req_valid, req_rw, req_addr, req_lmul, wdata_valid, wdata, rf_rdata,
    input  req_ready, req_err, wdata_ready, rdata_valid, rdata, rdata_idx, rdata_last,
           rf_en, rf_rw, rf_addr, rf_wdata
  );
endinterface

// File: rtl/vec_rf_rd_tag_pipe.sv
// vec_rf_rd_tag_pipe: RF_LAT-deep {valid, idx, last} delay line aligned with the
// regfile read latency, plus the registered read-beat output stage.
//   in_valid/in_idx/in_last  tag of the read issued this cycle
//   rf_rdata                 regfile data_out
//   busy                     any read still inside the delay line
//   rdata_*                  registered read beat (1 + RF_LAT cycles after issue)
module vec_rf_rd_tag_pipe #(
  parameter int VLEN_B = 128,
  parameter int RF_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [2:0]        in_idx,
  input  logic              in_last,
  input  logic [VLEN_B-1:0] rf_rdata,
  output logic              busy,
  output logic              rdata_valid,
  output logic [VLEN_B-1:0] rdata,
  output logic [2:0]        rdata_idx,
  output logic              rdata_last
);
  logic [RF_LAT-1:0] v;
  logic [RF_LAT-1:0] l;
  logic [2:0]        ix [RF_LAT];
  logic              hit;
  assign hit  = v[RF_LAT-1];
  assign busy = |v;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v           <= '0;
      l           <= '0;
      for (int i = 0; i < RF_LAT; i++) ix[i] <= '0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      rdata_idx   <= '0;
      rdata_last  <= 1'b0;
    end else begin
      v[0]  <= in_valid;
      l[0]  <= in_last;
      ix[0] <= in_idx;
      for (int i = 1; i < RF_LAT; i++) begin
        v[i]  <= v[i-1];
        l[i]  <= l[i-1];
        ix[i] <= ix[i-1];
      end
      // the oldest tag lines up with the cycle its data sits on rf_rdata
      rdata_valid <= hit;
      rdata       <= hit ? rf_rdata : '0;
      rdata_idx   <= hit ? ix[RF_LAT-1] : '0;
      rdata_last  <= hit && l[RF_LAT-1];
    end
  end
endmodule

// File: rtl/vec_rf_requester.sv
// vec_rf_requester: sequences single/LMUL-group register reads and writes onto
// one vector regfile port, one register per cycle.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         vec_rf_requester_if.slave: request handshake, write beats in,
//               read beats out (idx/last tagged), regfile port
module vec_rf_requester
  import vec_rf_pkg::*;
#(
  parameter int VLEN_B     = 128,
  parameter int ADDR_WIDTH = 5,
  parameter int RF_LAT     = 1
) (
  input logic              clk,
  input logic              rst_n,
  vec_rf_requester_if.slave bus
);
  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            nm1;
  logic [2:0]            cnt;
  logic [2:0]            req_nm1;
  logic                  legal;
  logic                  accept;
  logic                  last_beat;
  logic                  err_q;
  logic                  pipe_busy;
  assign req_nm1   = 3'(lmul_to_nregs(bus.req_lmul) - 4'd1);
  // a group must start on a multiple of its size, which also keeps base+cnt in range
  assign legal     = (bus.req_addr & ADDR_WIDTH'(req_nm1)) == '0;
  assign accept    = state == IDLE && bus.req_valid && legal;
  assign last_beat = cnt == nm1;
  assign bus.req_ready   = state == IDLE;
  assign bus.req_err     = err_q;
  assign bus.wdata_ready = state == WR;
  assign bus.rf_en       = state == RD || (state == WR && bus.wdata_valid);
  assign bus.rf_rw       = state == WR ? RF_WR : RF_RD;
  assign bus.rf_addr     = (state == RD || state == WR) ? base + ADDR_WIDTH'(cnt) : '0;
  assign bus.rf_wdata    = state == WR ? bus.wdata : '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = bus.req_rw ? WR : RD;
      RD:      if (last_beat) state_nx = DRAIN;
      WR:      if (bus.wdata_valid && last_beat) state_nx = IDLE;
      DRAIN:   if (!pipe_busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
      nm1   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= state == IDLE && bus.req_valid && !legal;
      if (accept) begin
        base <= bus.req_addr;
        nm1  <= req_nm1;
        cnt  <= '0;
      end else if (bus.rf_en) begin
        cnt <= cnt + 3'd1;
      end
    end
  end
  vec_rf_rd_tag_pipe #(.VLEN_B(VLEN_B), .RF_LAT(RF_LAT)) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (state == RD),
    .in_idx     (cnt),
    .in_last    (last_beat),
    .rf_rdata   (bus.rf_rdata),
    .busy       (pipe_busy),
    .rdata_valid(bus.rdata_valid),
    .rdata      (bus.rdata),
    .rdata_idx  (bus.rdata_idx),
    .rdata_last (bus.rdata_last)
  );
endmodule

// File: tb/tb_vec_rf_requester.sv
// tb_vec_rf_requester: directed plus random requests against a regfile model and a shadow-memory reference.
module tb_vec_rf_requester;
  localparam int RF_LAT = 3;
  localparam logic [127:0] V3 = 128'hABCDEF0123456789;
  typedef struct packed {logic [31:0] c; logic [127:0] d; logic [2:0] idx; logic last;} beat_t;
  typedef struct packed {logic [31:0] c; logic [4:0] a; logic [127:0] d;} wr_t;
  typedef struct packed {logic [31:0] c; logic [4:0] a;} ra_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [127:0] mem [32];
  logic [127:0] sh [32];
  logic [127:0] rp [RF_LAT];
  beat_t got_rd[$], exp_rd[$];
  wr_t got_wr[$], exp_wr[$];
  ra_t got_ra[$], exp_ra[$];
  int got_err[$];
  vec_rf_requester_if #(.VLEN_B(128), .ADDR_WIDTH(5)) bus ();
  vec_rf_requester #(.VLEN_B(128), .ADDR_WIDTH(5), .RF_LAT(RF_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (!rst_n) for (int i = 0; i < 32; i++) mem[i] <= (i == 3) ? V3 : 128'(i);
    else if (bus.rf_en && bus.rf_rw) mem[bus.rf_addr] <= bus.rf_wdata;
    rp[0] <= (bus.rf_en && !bus.rf_rw) ? mem[bus.rf_addr] : 128'h5A5A;
    for (int i = 1; i < RF_LAT; i++) rp[i] <= rp[i-1];
  end
  assign bus.rf_rdata = rp[RF_LAT-1];
  always @(negedge clk) begin
    if (bus.rdata_valid) got_rd.push_back(beat_t'{32'(cyc), bus.rdata, bus.rdata_idx, bus.rdata_last});
    if (bus.rf_en && bus.rf_rw) got_wr.push_back(wr_t'{32'(cyc), bus.rf_addr, bus.rf_wdata});
    if (bus.rf_en && !bus.rf_rw) got_ra.push_back(ra_t'{32'(cyc), bus.rf_addr});
    if (bus.req_err) got_err.push_back(cyc);
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [299:0] got, input logic [299:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic init_sh;
    for (int i = 0; i < 32; i++) sh[i] = (i == 3) ? V3 : 128'(i);
  endtask
  task automatic req(input logic rw, input int a, input int l, output int t);
    step;
    bus.req_valid = 1'b1;
    bus.req_rw = rw;
    bus.req_addr = 5'(a);
    bus.req_lmul = 2'(l);
    t = -1;
    for (int i = 0; i < 200 && t < 0; i++) begin
      if (bus.req_ready) t = cyc;
      else step;
    end
    chk("req_accept", 300'(t >= 0), 300'(1));
    step;
    bus.req_valid = 1'b0;
    bus.req_rw = 1'b0;
    bus.req_addr = '0;
    bus.req_lmul = '0;
  endtask
  task automatic rd_issue(input int a, input int l, output int t);
    req(1'b0, a, l, t);
    for (int i = 0; i < (1 << l); i++) begin
      exp_rd.push_back(beat_t'{32'(t + 2 + RF_LAT + i), sh[a+i], 3'(i), i == (1 << l) - 1});
      exp_ra.push_back(ra_t'{32'(t + 1 + i), 5'(a + i)});
    end
  endtask
  task automatic check_rd;
    for (int i = 0; i < 100 && got_rd.size() < exp_rd.size(); i++) step;
    repeat (RF_LAT + 2) step;
    chk("rd_count", 300'(got_rd.size()), 300'(exp_rd.size()));
    chk("ra_count", 300'(got_ra.size()), 300'(exp_ra.size()));
    foreach (exp_rd[i]) if (i < got_rd.size()) chk("rd_beat", 300'(got_rd[i]), 300'(exp_rd[i]));
    foreach (exp_ra[i]) if (i < got_ra.size()) chk("rd_issue", 300'(got_ra[i]), 300'(exp_ra[i]));
    got_rd.delete(); exp_rd.delete(); got_ra.delete(); exp_ra.delete();
  endtask
  task automatic wr_op(input int a, input int l, input bit rnd, output int t);
    int c;
    int g;
    logic [127:0] d;
    req(1'b1, a, l, t);
    c = t + 1;
    for (int i = 0; i < (1 << l); i++) begin
      g = rnd ? int'($urandom_range(0, 2)) : (i == 2 ? 2 : 0);
      repeat (g) begin
        bus.wdata_valid = 1'b0;
        step;
        c++;
      end
      d = rnd ? {$urandom, $urandom, $urandom, $urandom} : 128'(i + 1);
      bus.wdata_valid = 1'b1;
      bus.wdata = d;
      chk("wdata_ready", 300'(bus.wdata_ready), 300'(1));
      exp_wr.push_back(wr_t'{32'(c), 5'(a + i), d});
      sh[a+i] = d;
      step;
      c++;
    end
    bus.wdata_valid = 1'b0;
    bus.wdata = '0;
    chk("wr_ready_after", 300'(bus.req_ready), 300'(1));
    chk("wr_count", 300'(got_wr.size()), 300'(exp_wr.size()));
    foreach (exp_wr[i]) if (i < got_wr.size()) chk("wr_beat", 300'(got_wr[i]), 300'(exp_wr[i]));
    got_wr.delete(); exp_wr.delete();
  endtask
  task automatic err_op(input logic rw, input int a, input int l);
    int t;
    req(rw, a, l, t);
    chk("err_ready", 300'(bus.req_ready), 300'(1));
    step;
    step;
    chk("err_count", 300'(got_err.size()), 300'(1));
    if (got_err.size() > 0) chk("err_cycle", 300'(got_err[0]), 300'(t + 1));
    chk("err_no_rd", 300'(got_ra.size()), 300'(0));
    chk("err_no_wr", 300'(got_wr.size()), 300'(0));
    got_err.delete();
  endtask
  initial begin
    int t, t2, rc, kind, l, n, a;
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0; bus.req_lmul = '0;
    bus.wdata_valid = 1'b0; bus.wdata = '0;
    init_sh();
    repeat (3) step;
    chk("rst_outs", 300'({bus.req_err, bus.wdata_ready, bus.rdata_valid, bus.rdata, bus.rdata_idx,
        bus.rdata_last, bus.rf_en, bus.rf_rw, bus.rf_addr, bus.rf_wdata}), 300'(0));
    chk("rst_ready", 300'(bus.req_ready), 300'(1));
    rst_n = 1'b1;
    step;
    rd_issue(3, 0, t);
    check_rd();
    wr_op(8, 2, 1'b0, t);
    rd_issue(16, 3, t);
    rc = -1;
    for (int i = 0; i < 60 && rc < 0; i++) begin
      if (bus.req_ready) rc = cyc;
      else step;
    end
    check_rd();
    chk("t3_ready_after_last", 300'(rc > t + 9 + RF_LAT), 300'(1));
    err_op(1'b0, 5, 1);
    rd_issue(6, 1, t);
    check_rd();
    rd_issue(0, 1, t);
    wr_op(0, 0, 1'b1, t2);
    check_rd();
    chk("t6_wr_after_rd", 300'(t2 > t + 3 + RF_LAT), 300'(1));
    for (int k = 0; k < 40; k++) begin
      kind = int'($urandom_range(0, 4));
      l = int'($urandom_range(0, 3));
      if (kind == 4 && l == 0) l = 1;
      n = 1 << l;
      a = int'($urandom_range(0, 31)) & ~(n - 1);
      if (kind < 2) begin
        rd_issue(a, l, t);
        check_rd();
      end else if (kind < 4) begin
        wr_op(a, l, 1'b1, t);
      end else begin
        err_op(1'($urandom_range(0, 1)), a | int'($urandom_range(1, n - 1)), l);
      end
    end
    chk("no_stray_err", 300'(got_err.size()), 300'(0));
    rd_issue(4, 2, t);
    step;
    step;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", 300'({bus.req_err, bus.wdata_ready, bus.rdata_valid, bus.rdata, bus.rdata_idx,
        bus.rdata_last, bus.rf_en, bus.rf_rw, bus.rf_addr, bus.rf_wdata}), 300'(0));
    got_rd.delete(); exp_rd.delete(); got_ra.delete(); exp_ra.delete();
    init_sh();
    step;
    step;
    rst_n = 1'b1;
    chk("t5_ready", 300'(bus.req_ready), 300'(1));
    repeat (RF_LAT + 8) step;
    chk("t5_no_rdata", 300'(got_rd.size()), 300'(0));
    chk("t5_no_rf", 300'(got_ra.size() + got_wr.size()), 300'(0));
    rd_issue(3, 0, t);
    check_rd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
